// File: rtl/vector_instr_sequencer.sv
// Instruction front end for the vector processor: buffers host instructions in a FIFO and
// presents each one on the instruction port for a fixed, opcode-dependent number of cycles.
module vector_instr_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LD_CYCLES  = 10,
  parameter int unsigned ST_CYCLES  = 10,
  parameter int unsigned ADD_CYCLES = 10,
  parameter int unsigned MUL_CYCLES = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [12:0]                  in_instr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         halt,
  output logic [12:0]                  instruction,
  output logic                         exec_active,
  output logic                         retire,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [15:0]                  retired_count,
  output logic                         idle
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned MaxLs  = (LD_CYCLES > ST_CYCLES) ? LD_CYCLES : ST_CYCLES;
  localparam int unsigned MaxAm  = (ADD_CYCLES > MUL_CYCLES) ? ADD_CYCLES : MUL_CYCLES;
  localparam int unsigned MaxHold = (MaxLs > MaxAm) ? MaxLs : MaxAm;
  // Counter only ever holds HOLD-1, so MaxHold-1 must fit.
  localparam int unsigned HoldW  = (MaxHold > 1) ? $clog2(MaxHold) : 1;

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  logic [12:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  state_e           state_q;
  logic [12:0]      instr_q;
  logic [HoldW-1:0] hold_q;
  logic             exec_q;
  logic             retire_q;
  logic [15:0]      retired_q;

  logic        push, pop, fifo_empty, issue_slot;
  logic [12:0] head;

  function automatic logic [HoldW-1:0] hold_init(input logic [1:0] op);
    logic [HoldW-1:0] h;
    case (op)
      2'b00:   h = HoldW'(LD_CYCLES - 1);
      2'b01:   h = HoldW'(ST_CYCLES - 1);
      2'b10:   h = HoldW'(ADD_CYCLES - 1);
      default: h = HoldW'(MUL_CYCLES - 1);
    endcase
    return h;
  endfunction

  assign in_ready   = (count_q != CntW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  // Issue decisions happen in IDLE, or on the final edge of a hold window.
  assign issue_slot = (state_q == StIdle) || (hold_q == '0);
  assign pop        = issue_slot && !fifo_empty && !halt;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      hold_q    <= '0;
      exec_q    <= 1'b0;
      retire_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pop) begin
            instr_q <= head;
            hold_q  <= hold_init(head[12:11]);
            state_q <= StExec;
            exec_q  <= 1'b1;
          end
        end
        StExec: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - HoldW'(1);
          end else begin
            retire_q  <= 1'b1;
            retired_q <= retired_q + 16'd1;
            if (pop) begin
              instr_q <= head;
              hold_q  <= hold_init(head[12:11]);
            end else begin
              state_q <= StIdle;
              exec_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instruction   = instr_q;
  assign exec_active   = exec_q;
  assign retire        = retire_q;
  assign fifo_count    = count_q;
  assign retired_count = retired_q;
  assign idle          = (state_q == StIdle) && fifo_empty;

endmodule

// File: tb/tb_vector_instr_sequencer.sv
// Scoreboard bench for vector_instr_sequencer: pushed instructions are queued and matched
// against each observed hold window, whose length is predicted from the opcode.
module tb_vector_instr_sequencer;

  localparam int unsigned Depth = 8;
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [12:0]     in_instr = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            halt = 1'b0;
  logic [12:0]     instruction;
  logic            exec_active;
  logic            retire;
  logic [CntW-1:0] fifo_count;
  logic [15:0]     retired_count;
  logic            idle;

  vector_instr_sequencer #(
    .DEPTH      (Depth),
    .LD_CYCLES  (10),
    .ST_CYCLES  (7),
    .ADD_CYCLES (5),
    .MUL_CYCLES (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_instr      (in_instr),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .halt          (halt),
    .instruction   (instruction),
    .exec_active   (exec_active),
    .retire        (retire),
    .fifo_count    (fifo_count),
    .retired_count (retired_count),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [12:0] sb [$];
  logic [12:0] cur = '0;
  int          left = 0;
  bit          ret_pend = 1'b0;
  int unsigned exp_retired = 0;
  int unsigned peak = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hold_of(input logic [1:0] op);
    case (op)
      2'b00:   return 10;
      2'b01:   return 7;
      2'b10:   return 5;
      default: return 3;
    endcase
  endfunction

  // Tracks each hold window: its content, its length and the retire pulse that follows it.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      left        = 0;
      ret_pend    = 1'b0;
      exp_retired = 0;
    end else begin
      check("retire", 32'(retire), 32'(ret_pend));
      if (ret_pend) begin
        exp_retired++;
        check("retired_count", 32'(retired_count), 32'(exp_retired & 16'hFFFF));
      end
      ret_pend = 1'b0;
      if (left == 0 && exec_active) begin
        if (sb.size() == 0) check("sb_nonempty", 32'(sb.size()), 32'd1);
        else begin
          cur  = sb.pop_front();
          left = hold_of(cur[12:11]);
        end
      end
      if (left > 0) begin
        check("exec_active", 32'(exec_active), 32'd1);
        check("instruction", 32'(instruction), 32'(cur));
        left--;
        if (left == 0) ret_pend = 1'b1;
      end
      if (32'(fifo_count) > peak) peak = 32'(fifo_count);
    end
  end

  task automatic push(input logic [12:0] x);
    int n = 0;
    in_instr = x;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("push_ready", 32'(in_ready), 32'd1);
    else begin
      @(posedge clk);
      sb.push_back(x);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(idle && !exec_active) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check(tag, 32'(idle), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"}, 32'(instruction), 32'h0);
    check({tag, "_exec"}, 32'(exec_active), 32'd0);
    check({tag, "_retire"}, 32'(retire), 32'd0);
    check({tag, "_retired"}, 32'(retired_count), 32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check_reset_vals("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals("post_rst");

    // Single instruction: one-edge issue latency, then a full window and one retire.
    push(13'h0A05);
    check("lat_pre_exec", 32'(exec_active), 32'd0);
    check("lat_pre_count", 32'(fifo_count), 32'd1);
    @(posedge clk);
    #1;
    check("lat_instr", 32'(instruction), 32'h0A05);
    check("lat_exec", 32'(exec_active), 32'd1);
    check("lat_count", 32'(fifo_count), 32'd0);
    wait_idle("single_idle");
    check("single_retired", 32'(retired_count), 32'd1);
    check("single_keeps_instr", 32'(instruction), 32'h0A05);

    // Back-to-back: load, load, add, store.
    peak = 0;
    push(13'h0205);
    push(13'h0406);
    push(13'h1003);
    push(13'h0A10);
    wait_idle("b2b_idle");
    check("b2b_peak", peak, 32'd3);
    check("b2b_retired", 32'(retired_count), 32'd5);

    // Fill the FIFO while the first instruction holds; the next offer must stall.
    push(13'h0001);
    for (int i = 0; i < 8; i++) push({i[1:0], 11'(i + 16)});
    check("full_count", 32'(fifo_count), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    push(13'h1FFF);
    wait_idle("full_idle");
    check("full_retired", 32'(retired_count), 32'd15);

    // Short windows: mul then add.
    push(13'h1812);
    push(13'h1023);
    wait_idle("short_idle");
    check("short_retired", 32'(retired_count), 32'd17);

    // Halt mid-hold with two queued.
    push(13'h0111);
    push(13'h0A22);
    push(13'h1033);
    halt = 1'b1;
    begin
      int n = 0;
      while (!retire && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("halt_retire_seen", 32'(retire), 32'd1);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("halt_exec", 32'(exec_active), 32'd0);
    check("halt_count", 32'(fifo_count), 32'd2);
    check("halt_idle", 32'(idle), 32'd0);
    check("halt_retired", 32'(retired_count), 32'd18);
    halt = 1'b0;
    @(posedge clk);
    #1;
    check("unhalt_exec", 32'(exec_active), 32'd1);
    check("unhalt_instr", 32'(instruction), 32'h0A22);
    wait_idle("unhalt_idle");
    check("unhalt_retired", 32'(retired_count), 32'd20);

    // Reset in cycle 4 of a hold with three queued.
    push(13'h0044);
    push(13'h0855);
    push(13'h1066);
    push(13'h1877);
    @(posedge clk);
    #1;
    check("prerst_exec", 32'(exec_active), 32'd1);
    check("prerst_count", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("after_rst_retire", 32'(retire), 32'd0);
    push(13'h1888);
    @(posedge clk);
    #1;
    check("after_rst_instr", 32'(instruction), 32'h1888);
    wait_idle("after_rst_idle");
    check("after_rst_retired", 32'(retired_count), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
